// File: rtl/p_i_cache_control_pkg.sv
// Shared types for the pipelined I-cache controller and its PLRU helper.
package p_i_cache_control_pkg;

   localparam int num_ways  = 4;
   localparam int lru_width = 3;

   typedef enum logic [1:0] {
      no_write        = 2'b00,
      mem_write_cache = 2'b01,
      cpu_write_cache = 2'b10
   } dataarraymux_sel_t;

   typedef enum logic [1:0] {
      CHECK  = 2'b00,
      MISS   = 2'b01,
      REPLAY = 2'b10
   } p_i_cache_state_t;

   // Lowest set bit; returns 0 for an empty vector.
   function automatic logic [1:0] first_set(input logic [3:0] v);
      first_set = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (v[i]) first_set = 2'(i);
   endfunction

endpackage

// File: rtl/plru_4way.sv
// 4-way tree-PLRU: victim select (invalid ways first) and access update.
module plru_4way
   import p_i_cache_control_pkg::*;
(
   input  logic [3:0] valid,
   input  logic [2:0] lru,
   input  logic [1:0] access_way,
   output logic [1:0] victim,
   output logic [2:0] lru_next
);

   always_comb begin
      victim = 2'd0;
      if (valid != 4'hf)
         victim = first_set(~valid);
      else if (!lru[0])
         victim = lru[1] ? 2'd1 : 2'd0;
      else
         victim = lru[2] ? 2'd3 : 2'd2;
   end

   always_comb begin
      lru_next = lru;
      case (access_way)
         2'd0: begin lru_next[0] = 1'b1; lru_next[1] = 1'b1; end
         2'd1: begin lru_next[0] = 1'b1; lru_next[1] = 1'b0; end
         2'd2: begin lru_next[0] = 1'b0; lru_next[2] = 1'b1; end
         default: begin lru_next[0] = 1'b0; lru_next[2] = 1'b0; end
      endcase
   end

endmodule

// File: rtl/p_i_cache_control.sv
// I-cache sequencer: CHECK / MISS / REPLAY with PLRU victim fill.
// Define P_I_CACHE_PERF_EN to add saturating hit/miss counters.
module p_i_cache_control
   import p_i_cache_control_pkg::*;
#(
   parameter int num_ways  = 4,
   parameter int lru_width = 3
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_read,
   input  logic                          hit,
   input  logic [num_ways-1:0]           way_hit,
   input  logic [num_ways-1:0]           v_dataout,
   input  logic [lru_width-1:0]          LRU_array_dataout,
   input  logic                          pmem_resp,
   output logic                          pmem_read,
   output logic                          mem_resp,
   output logic                          stall,
   output logic [num_ways-1:0]           v_array_load,
   output logic [num_ways-1:0]           v_array_datain,
   output logic [num_ways-1:0]           tag_array_load,
   output logic                          LRU_array_load,
   output logic [lru_width-1:0]          LRU_array_datain,
   output dataarraymux_sel_t [num_ways-1:0] write_en_MUX_sel,
   output dataarraymux_sel_t [num_ways-1:0] data_array_datain_MUX_sel
`ifdef P_I_CACHE_PERF_EN
   ,
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count
`endif
);

   p_i_cache_state_t state_q;
   logic [1:0] victim_q;
   logic [1:0] victim_sel;
   logic [1:0] hit_way;
   logic [2:0] lru_next;

   assign hit_way = first_set(way_hit);

   plru_4way u_plru (
      .valid      (v_dataout),
      .lru        (LRU_array_dataout),
      .access_way (hit_way),
      .victim     (victim_sel),
      .lru_next   (lru_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CHECK;
         victim_q <= 2'd0;
      end else begin
         case (state_q)
            CHECK:
               if (mem_read && !hit) begin
                  state_q  <= MISS;
                  victim_q <= victim_sel;
               end
            MISS:
               if (pmem_resp) state_q <= REPLAY;
            REPLAY:
               state_q <= CHECK;
            default:
               state_q <= CHECK;
         endcase
      end
   end

   // Outputs are gated by rst so reset (including mid-MISS) loads nothing.
   always_comb begin
      pmem_read                 = 1'b0;
      mem_resp                  = 1'b0;
      stall                     = 1'b0;
      v_array_load              = '0;
      v_array_datain            = '0;
      tag_array_load            = '0;
      LRU_array_load            = 1'b0;
      LRU_array_datain          = '0;
      write_en_MUX_sel          = {num_ways{no_write}};
      data_array_datain_MUX_sel = {num_ways{no_write}};
      if (!rst) begin
         case (state_q)
            CHECK:
               if (mem_read) begin
                  if (hit) begin
                     mem_resp         = 1'b1;
                     LRU_array_load   = 1'b1;
                     LRU_array_datain = lru_next;
                  end else begin
                     stall = 1'b1;
                  end
               end
            MISS: begin
               pmem_read = 1'b1;
               stall     = 1'b1;
               if (pmem_resp) begin
                  v_array_load[victim_q]              = 1'b1;
                  v_array_datain[victim_q]            = 1'b1;
                  tag_array_load[victim_q]            = 1'b1;
                  write_en_MUX_sel[victim_q]          = mem_write_cache;
                  data_array_datain_MUX_sel[victim_q] = mem_write_cache;
               end
            end
            REPLAY:
               stall = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef P_I_CACHE_PERF_EN
   logic replay_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         replay_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         replay_q <= (state_q == REPLAY);
         if (state_q == CHECK && mem_read) begin
            if (hit && !replay_q && hit_count != '1)
               hit_count <= hit_count + 32'd1;
            if (!hit && miss_count != '1)
               miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   a_way_hit_onehot: assert property (
      @(posedge clk) disable iff (rst)
      (state_q == CHECK && mem_read && hit) |-> $onehot0(way_hit)
   );
`endif

endmodule

// File: tb/tb_p_i_cache_control.sv
// Directed bench for p_i_cache_control with immediate-assertion checks.
module tb_p_i_cache_control;
   import p_i_cache_control_pkg::*;

   logic clk = 1'b0;
   logic rst, mem_read, hit, pmem_resp;
   logic [3:0] way_hit, v_dataout;
   logic [2:0] lru_out;
   logic pmem_read, mem_resp, stall, lru_load;
   logic [3:0] v_load, v_datain, tag_load;
   logic [2:0] lru_datain;
   dataarraymux_sel_t [3:0] wsel, dsel;
`ifdef P_I_CACHE_PERF_EN
   logic [31:0] hit_count, miss_count;
`endif

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   p_i_cache_control dut (
      .clk                       (clk),
      .rst                       (rst),
      .mem_read                  (mem_read),
      .hit                       (hit),
      .way_hit                   (way_hit),
      .v_dataout                 (v_dataout),
      .LRU_array_dataout         (lru_out),
      .pmem_resp                 (pmem_resp),
      .pmem_read                 (pmem_read),
      .mem_resp                  (mem_resp),
      .stall                     (stall),
      .v_array_load              (v_load),
      .v_array_datain            (v_datain),
      .tag_array_load            (tag_load),
      .LRU_array_load            (lru_load),
      .LRU_array_datain          (lru_datain),
      .write_en_MUX_sel          (wsel),
      .data_array_datain_MUX_sel (dsel)
`ifdef P_I_CACHE_PERF_EN
      ,
      .hit_count                 (hit_count),
      .miss_count                (miss_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Full miss: entry, latched victim, fill, replay.
   task automatic do_miss(input string tag, input logic [3:0] v,
                          input logic [2:0] lru, input logic [3:0] exp_way,
                          input logic [7:0] exp_sel);
      mem_read = 1'b1; hit = 1'b0; way_hit = 4'b0;
      v_dataout = v; lru_out = lru; pmem_resp = 1'b0;
      settle();
      chk({tag, "_stall"}, 32'(stall), 1);
      tick();
      mem_read = 1'b0; v_dataout = 4'b0000; lru_out = ~lru;
      settle();
      chk({tag, "_pmem_read"}, 32'(pmem_read), 1);
      chk({tag, "_no_early_load"}, 32'(v_load), 0);
      tick();
      pmem_resp = 1'b1;
      settle();
      chk({tag, "_v_load"}, 32'(v_load), 32'(exp_way));
      chk({tag, "_tag_load"}, 32'(tag_load), 32'(exp_way));
      chk({tag, "_v_datain"}, 32'(v_datain), 32'(exp_way));
      chk({tag, "_wsel"}, 32'(wsel), 32'(exp_sel));
      chk({tag, "_dsel"}, 32'(dsel), 32'(exp_sel));
      chk({tag, "_fill_no_lru"}, 32'(lru_load), 0);
      tick();
      pmem_resp = 1'b0;
      settle();
      chk({tag, "_replay"}, 32'({pmem_read, stall, |v_load}), 'b010);
      tick();
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b1; hit = 1'b1; way_hit = 4'b0001;
      v_dataout = 4'b0; lru_out = 3'b0; pmem_resp = 1'b1;
      tick();
      settle();
      chk("rst_outputs",
          32'({pmem_read, mem_resp, stall, lru_load, v_load, tag_load}),
          0);
      chk("rst_sel", 32'({wsel, dsel}), 0);
      tick();
      rst = 1'b0; mem_read = 1'b0; hit = 1'b0; way_hit = 4'b0;
      pmem_resp = 1'b0;
      settle();
      chk("idle", 32'({pmem_read, mem_resp, stall, lru_load}), 0);

      // Cold miss into way 0, then the replay hit responds.
      do_miss("cold", 4'b0000, 3'b000, 4'b0001, 8'b00000001);
      mem_read = 1'b1; hit = 1'b1; way_hit = 4'b0001;
      v_dataout = 4'b0001; lru_out = 3'b000;
      settle();
      chk("cold_resp", 32'({mem_resp, stall}), 'b10);
      chk("cold_lru", 32'({lru_load, lru_datain}), 'b1011);
      tick();
      mem_read = 1'b0; hit = 1'b0; way_hit = 4'b0;

      do_miss("plru000", 4'b1111, 3'b000, 4'b0001, 8'b00000001);
      do_miss("plru101", 4'b1111, 3'b101, 4'b1000, 8'b01000000);
      do_miss("plru001", 4'b1111, 3'b001, 4'b0100, 8'b00010000);
      do_miss("inval",   4'b1011, 3'b000, 4'b0100, 8'b00010000);

      // Back-to-back hits with the PLRU fed back.
      mem_read = 1'b1; hit = 1'b1; v_dataout = 4'b1111;
      way_hit = 4'b0100; lru_out = 3'b000;
      settle();
      chk("hit2", 32'({mem_resp, stall, lru_datain}), 'b10100);
      tick();
      way_hit = 4'b0010; lru_out = 3'b100;
      settle();
      chk("hit1", 32'({mem_resp, stall, lru_datain}), 'b10101);
      tick();
      way_hit = 4'b1000; lru_out = 3'b111;
      settle();
      chk("hit3", 32'(lru_datain), 'b010);
      tick();

      // Reset two cycles into MISS abandons the fill.
      hit = 1'b0; way_hit = 4'b0; v_dataout = 4'b0000;
      tick();
      mem_read = 1'b0;
      tick();
      rst = 1'b1; pmem_resp = 1'b1;
      settle();
      chk("rst_miss_no_load", 32'({v_load, tag_load, pmem_read}), 0);
      tick();
      rst = 1'b0; pmem_resp = 1'b0;
      settle();
      chk("rst_miss_after", 32'({pmem_read, stall}), 0);
      mem_read = 1'b1; hit = 1'b1; way_hit = 4'b0001; lru_out = 3'b000;
      settle();
      chk("rst_miss_check", 32'({mem_resp, lru_datain}), 'b1011);
      tick();

`ifdef P_I_CACHE_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_read = 1'b1; hit = 1'b1; way_hit = 4'b0010;
      tick();
      tick();
      tick();
      do_miss("perf", 4'b0000, 3'b000, 4'b0001, 8'b00000001);
      mem_read = 1'b1; hit = 1'b1; way_hit = 4'b0001;
      tick();
      mem_read = 1'b0; hit = 1'b0;
      settle();
      chk("hit_count", hit_count, 3);
      chk("miss_count", miss_count, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
